// File: rtl/data_sram_resp.sv
// Data-side SRAM responder: RAM window, timer/status MMIO and a 4-deep store-trace FIFO.
// Zero-latency combinational reads, writes at the clock edge; trace pushes into a full FIFO are dropped and flagged.

// Generic sync FIFO; a push into a full FIFO is accepted only when a pop frees a slot the same cycle.
// One-cycle write-to-visible latency; a refused push raises ovf for that cycle.
module trace_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push_vld,
  input  logic [W-1:0]               push_dat,
  input  logic                       pop_rdy,
  output logic                       pop_vld,
  output logic [W-1:0]               pop_dat,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       ovf
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          full, do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign pop_vld = (count != '0);
  assign do_pop  = pop_rdy && pop_vld;
  assign do_push = push_vld && (!full || do_pop);
  assign ovf     = push_vld && full && !do_pop;
  assign pop_dat = pop_vld ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end
endmodule

// Top: decodes the core's data-SRAM bus into RAM and MMIO, traces every accepted store.
module data_sram_resp #(
  parameter int RAM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic        dbg_pop,
  output logic        dbg_valid,
  output logic [31:0] dbg_addr,
  output logic [31:0] dbg_data,
  output logic        err_out
);
  localparam int          AW        = $clog2(RAM_WORDS);
  localparam logic [31:0] RAM_BASE  = 32'h1c80_0000;
  localparam logic [27:0] MMIO_PAGE = 28'h1c8_1000;

  logic [31:0]   mem [RAM_WORDS];
  logic [31:0]   cycle_q, cmp_q;
  logic [1:0]    stat_q, stat_d;
  logic          err_q;
  logic [2:0]    tcnt;
  logic [63:0]   trace_dat;
  logic          trace_ovf;

  logic          ram_hit, mmio_hit, misaligned, wr_ok;
  logic          ram_we, wr_cmp, wr_stat, expired_set;
  logic [AW-1:0] ram_idx;
  logic [1:0]    mmio_sel;

  assign ram_hit    = (data_sram_addr[31:AW+2] == RAM_BASE[31:AW+2]);
  assign mmio_hit   = (data_sram_addr[31:4] == MMIO_PAGE);
  assign misaligned = |data_sram_addr[1:0];
  assign ram_idx    = data_sram_addr[AW+1:2];
  assign mmio_sel   = data_sram_addr[3:2];

  // rstn gates the write so a store pending while reset is held is never performed.
  assign wr_ok   = rstn && data_sram_we && (ram_hit || mmio_hit) && !misaligned;
  assign ram_we  = wr_ok && ram_hit;
  assign wr_cmp  = wr_ok && mmio_hit && (mmio_sel == 2'd1);
  assign wr_stat = wr_ok && mmio_hit && (mmio_sel == 2'd2);

  always_comb begin
    data_sram_rdata = '0;
    if (ram_hit) begin
      data_sram_rdata = mem[ram_idx];
    end else if (mmio_hit) begin
      case (mmio_sel)
        2'd0:    data_sram_rdata = cycle_q;
        2'd1:    data_sram_rdata = cmp_q;
        2'd2:    data_sram_rdata = {30'b0, stat_q};
        default: data_sram_rdata = {29'b0, tcnt};
      endcase
    end
  end

  // A set condition overrides a simultaneous write-1-to-clear.
  assign expired_set = (cycle_q == cmp_q) && (cmp_q != '0);
  assign stat_d[0]   = expired_set | (stat_q[0] & ~(wr_stat & data_sram_wdata[0]));
  assign stat_d[1]   = trace_ovf   | (stat_q[1] & ~(wr_stat & data_sram_wdata[1]));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cycle_q <= '0;
      cmp_q   <= '0;
      stat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (wr_cmp) cmp_q <= data_sram_wdata;
      stat_q  <= stat_d;
      err_q   <= err_q | !(ram_hit || mmio_hit) | misaligned;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_idx] <= data_sram_wdata;
  end

  trace_fifo #(.W(64), .DEPTH(4)) u_trace (
    .clk      (clk),
    .rstn     (rstn),
    .push_vld (wr_ok),
    .push_dat ({data_sram_addr, data_sram_wdata}),
    .pop_rdy  (dbg_pop),
    .pop_vld  (dbg_valid),
    .pop_dat  (trace_dat),
    .count    (tcnt),
    .ovf      (trace_ovf)
  );

  assign dbg_addr = trace_dat[63:32];
  assign dbg_data = trace_dat[31:0];
  assign err_out  = err_q;
endmodule

// File: doc/data_sram_resp.md
DATA_SRAM_RESP -- requirements
Module: data_sram_resp

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 256, number of 32-bit RAM words (power of two, max 1024).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port data_sram_we  input  1  store strobe from core MEM stage.
REQ-005 SHALL have port data_sram_addr  input  32  byte address from core.
REQ-006 SHALL have port data_sram_wdata  input  32  store data.
REQ-007 SHALL have port data_sram_rdata  output  32  load data, combinational from addr.
REQ-008 SHALL have port dbg_pop  input  1  pop one store-trace entry.
REQ-009 SHALL have port dbg_valid  output  1  trace FIFO non-empty.
REQ-010 SHALL have port dbg_addr  output  32  address of oldest trace entry.
REQ-011 SHALL have port dbg_data  output  32  data of oldest trace entry.
REQ-012 SHALL have port err_out  output  1  sticky access-error flag.

Function
REQ-013 SHALL decode the RAM window as 0x1c80_0000 to 0x1c80_0000+4*RAM_WORDS-1, word index addr[log2(RAM_WORDS)+1:2].
REQ-014 SHALL decode the MMIO window: 0x1c81_0000 CYCLE (RO), 0x1c81_0004 CMP (RW), 0x1c81_0008 STAT (bit0 expired, bit1 trace overflow; write-1-to-clear), 0x1c81_000C TCNT (RO, trace occupancy 0-4).
REQ-015 SHALL return read data combinationally in the same cycle addr is presented, so the core samples it at the MEM/WB edge; zero added latency.
REQ-016 SHALL perform writes at the rising edge where data_sram_we=1; a read of the same address in that cycle returns the old value.
REQ-017 SHALL treat unmapped addresses as: read 0, write ignored, err_out set.
REQ-018 SHALL on addr[1:0]!=0 set err_out, ignore any write, and return the word at the aligned address on read.
REQ-019 SHALL ignore writes to CYCLE and TCNT without setting err_out.
REQ-020 SHALL increment CYCLE by 1 every clock, wrapping 0xFFFF_FFFF to 0.
REQ-021 SHALL set STAT.bit0 when CYCLE==CMP and CMP!=0; a same-cycle set and write-1-clear leaves bit0 = 1 (set wins).
REQ-022 SHALL push {addr,wdata} into a 4-entry FIFO on every accepted write (RAM or MMIO).
REQ-023 SHALL, when the FIFO is full and no pop occurs, drop the new entry and set STAT.bit1.
REQ-024 SHALL, on simultaneous push and pop while full, perform both; occupancy stays 4 and no overflow is flagged.
REQ-025 SHALL ignore dbg_pop while empty, without error.
REQ-026 SHALL drive dbg_addr/dbg_data from the head entry; they are 0 when empty.
REQ-027 SHALL wrap FIFO read/write pointers modulo 4, with occupancy held in a 3-bit counter.
REQ-028 SHALL keep err_out set until reset; no software clear.

Reset
REQ-029 SHALL, while rstn=0, force CYCLE=0, CMP=0, STAT=0, FIFO empty (pointers and count 0), and err_out=0.
REQ-030 SHALL leave RAM contents undefined on reset (not cleared) and leave an in-flight write unperformed when rstn is low at the edge.
REQ-031 SHALL, during reset, drive dbg_valid=0, dbg_addr=0 and dbg_data=0; data_sram_rdata follows decode (MMIO reads 0).

Verification
REQ-032 SHALL verify: write 0x1c80_0010<-0xDEADBEEF, then read 0x1c80_0010 -> rdata 0xDEADBEEF; dbg_valid=1, dbg_addr=0x1c80_0010, dbg_data=0xDEADBEEF.
REQ-033 SHALL verify: five writes with no pop -> TCNT=4, STAT=0x2, head is the first write; pop 4 times -> dbg_valid=0.
REQ-034 SHALL verify: with FIFO full, assert push and pop in the same cycle -> TCNT stays 4, head advances, STAT.bit1 stays 0.
REQ-035 SHALL verify: CMP<-CYCLE+20 -> STAT.bit0=1 after 20 cycles; write STAT<-1 -> reads 0; write-clear in the match cycle -> bit0 remains 1.
REQ-036 SHALL verify: read 0x0000_0000 -> 0 and err_out=1; write 0x1c80_0002 -> RAM unchanged and err_out stays 1.
REQ-037 SHALL verify: assert rstn=0 asynchronously mid-cycle with CYCLE=0x1234 and a write pending -> CYCLE, STAT, TCNT and err_out read 0 immediately and the write is not performed.
